// File: rtl/shifter_pkg.sv
// ============================================================================
//  Module   : shifter_pkg
//  Brief    : Shared operation/state encodings for the iterative shifter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : shifter_pkg

`default_nettype wire

// File: rtl/iterative_shifter_shift_step.sv
// ============================================================================
//  Module   : shift_step
//  Brief    : Combinational single-step shifter, 0..STEP positions per call.
//             Rotate path present only when SHIFTER_ROTATE_EN is defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [KW-1:0]    i_amt,
  input  logic [1:0]       i_op,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_fill;

  // Mask of the vacated upper bits, used to sign-extend arithmetic shifts.
  assign w_fill = ~({WIDTH{1'b1}} >> i_amt);

`ifdef SHIFTER_ROTATE_EN
  logic [2*WIDTH-1:0] w_dbl;
  assign w_dbl = {i_data, i_data} << i_amt;
`endif

  always_comb begin
    o_data = i_data << i_amt;
    case (shift_op_t'(i_op))
      OP_SRL: o_data = i_data >> i_amt;
      OP_SRA: o_data = (i_data >> i_amt) | (i_sign ? w_fill : '0);
`ifdef SHIFTER_ROTATE_EN
      OP_ROL: o_data = w_dbl[2*WIDTH-1:WIDTH];
`endif
      default: o_data = i_data << i_amt;
    endcase
  end

endmodule : shift_step

`default_nettype wire

// File: rtl/iterative_shifter.sv
// ============================================================================
//  Module   : iterative_shifter
//  Brief    : Multi-cycle SLL/SRL/SRA (+ROL with SHIFTER_ROTATE_EN) unit,
//             at most STEP positions per clock, valid/ready on both sides.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)  // derived; leave at default
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int           KW     = $clog2(STEP + 1);
  localparam logic [SHW:0] C_STEP = (SHW + 1)'(STEP);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_rem;
  logic [1:0]       r_op;
  logic             r_sign;

  logic             w_in_ready;
  logic             w_accept;
  logic [SHW:0]     w_k;
  logic [SHW:0]     w_rem_ext;
  logic [WIDTH-1:0] w_step_out;

  // k = min(remaining, STEP), computed one bit wider so STEP == WIDTH fits.
  always_comb begin
    w_k       = ({1'b0, r_rem} < C_STEP) ? {1'b0, r_rem} : C_STEP;
    w_rem_ext = {1'b0, r_rem} - w_k;
  end

  assign w_in_ready = (r_state == IDLE) && rst_n;
  assign w_accept   = in_valid && w_in_ready;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_shift_step (
    .i_data (r_work),
    .i_amt  (w_k[KW-1:0]),
    .i_op   (r_op),
    .i_sign (r_sign),
    .o_data (w_step_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_op    <= '0;
      r_sign  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_work <= data_in;
        r_rem  <= shamt;
        r_op   <= op;
        r_sign <= data_in[WIDTH-1];
      end else if (r_state == SHIFT) begin
        r_work <= w_step_out;
        r_rem  <= w_rem_ext[SHW-1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = w_in_ready;
    out_valid    = 1'b0;
    busy         = 1'b1;
    result       = r_work;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          w_state_next = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (w_rem_ext == '0) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule : iterative_shifter

`default_nettype wire

// File: tb/tb_iterative_shifter.sv
// ============================================================================
//  Module   : tb_iterative_shifter
//  Brief    : Scoreboard bench for iterative_shifter (WIDTH=32, STEP=4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iterative_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] data_in = '0;
  logic [SHW-1:0]   shamt = '0;
  logic [1:0]       op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_accept_cyc = 0;
  int last_lat = 0;
  logic [WIDTH-1:0] exp_q[$];

  iterative_shifter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int s,
                                             input logic [1:0] o);
    case (o)
      2'b01: return d >> s;
      2'b10: return WIDTH'($signed(d) >>> s);
`ifdef SHIFTER_ROTATE_EN
      2'b11: return (d << s) | (d >> (WIDTH - s));
`else
      2'b11: return d << s;
`endif
      default: return d << s;
    endcase
  endfunction

  function automatic int exp_lat(input int s);
    return 1 + (s + STEP - 1) / STEP;
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] d, input int s, input logic [1:0] o,
                        input int hold);
    int lat;
    int waits;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] expv;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_idle: got %b want 1", in_ready);
    end
    waits = 0;
    while (in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    in_valid = 1'b1;
    data_in  = d;
    shamt    = s[SHW-1:0];
    op       = o;
    exp_q.push_back(model(d, s, o));
    last_accept_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = $urandom;
    shamt    = SHW'($urandom);
    op       = 2'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    last_lat = lat;
    n_vec++;
    if (lat != exp_lat(s)) begin
      n_err++;
      $display("FAIL latency op=%0d shamt=%0d: got %0d want %0d", o, s, lat, exp_lat(s));
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL in_ready_with_out_valid: got %b want 0", in_ready);
    end
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_vec++;
      if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_stable cyc%0d: result=%h ov=%b ir=%b want result=%h ov=1 ir=0",
                 i, result, out_valid, in_ready, held);
      end
    end
    expv = exp_q.pop_front();
    n_vec++;
    if (result !== expv) begin
      n_err++;
      $display("FAIL result op=%0d d=%h shamt=%0d: got %h want %h", o, d, s, result, expv);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL during_reset: ir=%b ov=%b busy=%b want 0 0 0", in_ready, out_valid, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset: ir=%b ov=%b result=%h busy=%b want 1 0 0 0",
               in_ready, out_valid, result, busy);
    end
  endtask

  task automatic test_basic;
    run_op(32'h0000_0002, 2, 2'b00, 0);
    run_op(32'hFFFF_FFFC, 2, 2'b10, 0);
    run_op(32'hFFFF_FFFC, 2, 2'b01, 0);
    run_op(32'h8000_0000, 31, 2'b01, 0);
    run_op(32'h8000_0000, 31, 2'b10, 1);
    run_op(32'h0000_0001, 31, 2'b00, 0);
    run_op(32'h1234_5678, 4, 2'b00, 0);
    run_op(32'h1234_5678, 5, 2'b01, 0);
  endtask

  task automatic test_zero_hold;
    run_op(32'hDEAD_BEEF, 0, 2'b00, 5);
    run_op(32'hCAFE_F00D, 0, 2'b10, 0);
    run_op(32'h8765_4321, 0, 2'b11, 2);
  endtask

  task automatic test_rotate;
    run_op(32'h8000_0001, 4, 2'b11, 0);
    run_op(32'hF000_000F, 7, 2'b11, 0);
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 32'h8000_0000;
    shamt    = 5'd31;
    op       = 2'b01;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_shift_busy: busy=%b ov=%b want 1 0", busy, out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: ir=%b ov=%b result=%h busy=%b want 1 0 0 0",
               in_ready, out_valid, result, busy);
    end
    run_op(32'h1234_5678, 9, 2'b10, 0);
    run_op(32'h9234_5678, 9, 2'b10, 0);
  endtask

  task automatic test_back_to_back;
    int c1;
    int l1;
    run_op(32'h0F0F_0F0F, 6, 2'b00, 0);
    c1 = last_accept_cyc;
    l1 = last_lat;
    run_op(32'hF0F0_F0F0, 13, 2'b10, 0);
    n_vec++;
    if (last_accept_cyc - c1 != l1 + 1) begin
      n_err++;
      $display("FAIL issue_interval: got %0d want %0d", last_accept_cyc - c1, l1 + 1);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      run_op($urandom, int'($urandom_range(0, WIDTH - 1)), 2'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_hold();
    test_rotate();
    test_mid_reset();
    test_back_to_back();
    test_random();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_iterative_shifter

`default_nettype wire

// File: doc/iterative_shifter.md
# iterative_shifter

Multi-cycle, parametrised shift unit for the processor's execute stage, replacing the fixed shift-left-by-2 block for all variable-amount shifts. Accepts an operand, shift amount and shift operation over a valid/ready handshake, shifts at most STEP bit positions per clock, and returns the result over a second valid/ready handshake. Supports logical left, logical right and arithmetic right shifts, with optional rotate-left.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1..WIDTH
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden
- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- data_in  in  WIDTH  operand
- shamt  in  SHW  shift amount, 0..WIDTH-1
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (see Configuration)
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- result  out  WIDTH  shifted operand
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On accept, latch data_in into the work register, shamt into the remaining-count register, and op into the op register. Go to SHIFT if shamt≠0, otherwise go to DONE.
- SHIFT: each cycle, shift the work register by k=min(remaining, STEP) and set remaining -= k. Go to DONE when the new remaining value is 0.
- DONE: out_valid=1, result=work register. Hold result stable until out_ready. On handshake, go to IDLE.
- SLL and SRL fill with 0. SRA fills with the latched operand's MSB. ROL rotates bits from MSB to LSB.
- All arithmetic is modulo WIDTH. shamt is already bounded by its width, so no out-of-range amounts exist.
- data_in, shamt and op are ignored outside the accept cycle.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after reset; out_valid=0; result=0; busy=0; state=IDLE; internal registers=0.
- With accept at cycle 0, out_valid rises at cycle 1+ceil(shamt/STEP). For shamt=0, out_valid rises at cycle 1.
- in_ready is never asserted in the same cycle as out_valid. There is no request/result overlap and no throughput beyond one operation in flight.
- out_ready held low keeps the block in DONE indefinitely, with result unchanged.
- Reset asserted in any state returns the block to IDLE at the next edge, with all outputs at reset values. An in-flight operation is discarded.
- The out_valid→out_ready handshake in DONE returns the block to IDLE. in_ready=1 in the following cycle, so the back-to-back issue interval is latency+1.

## Configuration
- SHIFTER_ROTATE_EN defined: op=11 performs ROL.
- SHIFTER_ROTATE_EN undefined: op=11 behaves exactly as SLL, and the rotate datapath is not synthesised.

## Structure
- Package shifter_pkg holds:
  - shift_op_t enum (OP_SLL, OP_SRL, OP_SRA, OP_ROL)
  - state_t enum (IDLE, SHIFT, DONE)
- Sub-module shift_step: combinational, parametrised by WIDTH and STEP. Shifts its input by 0..STEP positions for a given op and sign bit. Instantiated once, driving the work register.

## Test plan
- WIDTH=32, STEP=4: data_in=0x00000002, SLL, shamt=2 → result 0x00000008; out_valid at cycle 2.
- data_in=0xFFFFFFFC, SRA, shamt=2 → result 0xFFFFFFFF; SRL of the same operand → 0x3FFFFFFF.
- data_in=0x80000000, SRL, shamt=31 → result 0x00000001; out_valid at cycle 9 (ceil(31/4)=8).
- shamt=0 on any op → result=data_in at cycle 1. Hold out_ready=0 for 5 cycles → result stable, in_ready=0 throughout.
- op=11, data_in=0x80000001, shamt=4 → 0x00000018 with SHIFTER_ROTATE_EN defined, 0x00000010 without it.
- Assert rst_n=0 for one cycle mid-SHIFT → next cycle IDLE, out_valid=0, result=0, in_ready=1. A following request completes correctly.
